// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
// Both sides use these depth and address constants so they agree on the memory size.
package inst_mem_loader_pkg;

  localparam int MEM_WIDTH  = 128;
  localparam int ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    FINISH   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/inst_byte_packer.sv
// Collects four streamed bytes into one little-endian lane word.
// The memory's read-side byte swap later turns this into big-endian instruction order.
module inst_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] idx_reg;
  logic [7:0] lane_reg [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 2'd0;
    end else if (clear) begin
      idx_reg <= 2'd0;
    end else if (accept) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    // Lane gi is only loaded by the byte whose index equals gi.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_reg[gi] <= 8'd0;
      end else if (accept && !clear && (idx_reg == 2'(gi))) begin
        lane_reg[gi] <= in_byte;
      end
    end
    assign word[8*gi +: 8] = lane_reg[gi];
  end

  assign last = (idx_reg == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction memory.
// It packs four bytes per word and writes consecutive entries from a base address.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int MemWidth  = MEM_WIDTH,
  parameter int AddrWidth = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [AddrWidth:0]   word_count,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [7:0]           in_byte,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [AddrWidth:0] DEPTH = (AddrWidth+1)'(MemWidth);

  loader_state_t        state_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic [AddrWidth:0]   remaining_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic [AddrWidth:0] end_addr;
  logic               overflow;
  logic               accept;
  logic               clear;
  logic               last;

  // The end address is formed one bit wider so base + count can never alias.
  assign end_addr = {1'b0, base_addr} + word_count;
  assign overflow = (end_addr > DEPTH);

  assign in_ready = (state_reg == ASSEMBLE);
  assign mem_we   = (state_reg == WRITE);
  assign busy     = (state_reg == ASSEMBLE) || (state_reg == WRITE);
  assign mem_addr = addr_reg;
  assign done     = done_reg;
  assign error    = error_reg;

  assign accept = in_ready && in_valid;
  assign clear  = abort || (state_reg != ASSEMBLE);

  inst_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .clear   (clear),
    .in_byte (in_byte),
    .word    (mem_wdata),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (start) begin
              if (word_count == '0) begin
                state_reg <= FINISH;
              end else if (overflow) begin
                error_reg <= 1'b1;
              end else begin
                addr_reg      <= base_addr;
                remaining_reg <= word_count;
                state_reg     <= ASSEMBLE;
              end
            end
          end
          ASSEMBLE: begin
            if (accept && last) state_reg <= WRITE;
          end
          WRITE: begin
            addr_reg      <= addr_reg + AddrWidth'(1);
            remaining_reg <= remaining_reg - (AddrWidth+1)'(1);
            state_reg     <= (remaining_reg == (AddrWidth+1)'(1)) ? FINISH : ASSEMBLE;
          end
          FINISH: begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench: table of load scenarios against a queue-based byte/word model,
// plus hand-driven abort and asynchronous-reset sequences.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  base_addr;
  logic [7:0]  word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [31:0] mem_model [0:127];
  logic [7:0]  fixed_bytes [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};

  typedef struct {
    int base;
    int cnt;
    int gap;       // 0 continuous, 1 alternating valid, 2 random valid
    bit fixed;
    bit err;
    int done_cyc;  // -1 when the cycle depends on back-pressure
  } vec_t;

  vec_t tbl [9];

  inst_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // Issues one start and streams bytes; the model is a byte queue and an
  // expected-write queue built directly from base + i and the byte order.
  task automatic run_load(input int idx, input int base, input int cnt, input int gap,
                          input bit fixed, input bit exp_err, input int exp_done);
    logic [7:0]  bq [$];
    int          ea [$];
    logic [31:0] ed [$];
    logic [7:0]  b [4];
    int nw = 0, s, cyc, done_cyc = -1, err_cyc = -1, tail = 0;
    bit done_seen = 0, err_seen = 0, busy_seen = 0, pend = 0, v;
    int exp_words = exp_err ? 0 : cnt;

    for (int w = 0; w < exp_words; w++) begin
      for (int k = 0; k < 4; k++) begin
        b[k] = fixed ? fixed_bytes[4*w+k] : 8'($urandom);
        bq.push_back(b[k]);
      end
      ea.push_back(base + w);
      ed.push_back(32'(b[0]) + 32'(b[1]) * 256 + 32'(b[2]) * 65536 + 32'(b[3]) * 16777216);
    end

    @(negedge clk);
    base_addr = 7'(base); word_count = 8'(cnt); start = 1'b1;
    s = edge_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < cnt * 20 + 20; t++) begin
      cyc = edge_cnt - s;
      if (mem_we) begin
        nw++;
        mem_model[mem_addr] = mem_wdata;
        if (ea.size() > 0) begin
          chk($sformatf("v%0d_addr", idx), 32'(mem_addr), 32'(ea.pop_front()));
          chk($sformatf("v%0d_data", idx), mem_wdata, ed.pop_front());
        end
      end
      if (busy) busy_seen = 1;
      if (error && !err_seen) begin err_seen = 1; err_cyc = cyc; end
      if (done && !done_seen) begin done_seen = 1; done_cyc = cyc; end
      if (pend) void'(bq.pop_front());
      case (gap)
        0: v = 1'b1;
        1: v = (cyc % 2 == 1);
        default: v = 1'($urandom);
      endcase
      if (v && bq.size() > 0) begin
        in_valid = 1'b1; in_byte = bq[0];
      end else begin
        in_valid = 1'b0; in_byte = 8'($urandom);
      end
      pend = in_valid && in_ready;
      if (done_seen || err_seen) begin
        tail++;
        if (tail > 3) break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    chk($sformatf("v%0d_error_seen", idx), 32'(err_seen), 32'(exp_err));
    chk($sformatf("v%0d_done_seen", idx), 32'(done_seen), 32'(!exp_err));
    chk($sformatf("v%0d_write_count", idx), 32'(nw), 32'(exp_words));
    chk($sformatf("v%0d_busy_seen", idx), 32'(busy_seen), 32'(exp_words > 0));
    if (exp_err) chk($sformatf("v%0d_error_cycle", idx), 32'(err_cyc), 1);
    if (exp_done >= 0) chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(exp_done));
    if (!exp_err) chk($sformatf("v%0d_bytes_left", idx), 32'(bq.size()), 0);
  endtask

  initial begin
    int nwe, ndone, guard;

    tbl[0] = '{0,   2,   0, 1, 0, 12};
    tbl[1] = '{5,   1,   1, 0, 0, -1};
    tbl[2] = '{126, 3,   0, 0, 1, -1};
    tbl[3] = '{126, 2,   0, 0, 0, 12};
    tbl[4] = '{0,   0,   0, 0, 0, 2};
    tbl[5] = '{0,   128, 0, 0, 0, 642};
    tbl[6] = '{127, 1,   0, 0, 0, 7};
    tbl[7] = '{10,  5,   2, 0, 0, -1};
    tbl[8] = '{0,   129, 0, 0, 1, -1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_byte = 8'd0;
    base_addr = '0; word_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_load(i, tbl[i].base, tbl[i].cnt, tbl[i].gap, tbl[i].fixed, tbl[i].err, tbl[i].done_cyc);
      if (i == 0) begin
        chk("readback0", swap32(mem_model[0]), 32'h8C010004);
        chk("readback1", swap32(mem_model[1]), 32'h20020005);
      end
    end

    // Abort after two bytes of the first word.
    @(negedge clk);
    base_addr = 7'd20; word_count = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_byte = 8'hAA;
    @(negedge clk);
    in_byte = 8'hBB;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    nwe = 0; ndone = 0;
    in_valid = 1'b1; in_byte = 8'hCC;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (done) ndone++;
    end
    in_valid = 1'b0;
    chk("abort_no_writes", 32'(nwe), 0);
    chk("abort_no_done", 32'(ndone), 0);
    run_load(20, 20, 1, 0, 0, 0, 7);

    // Asynchronous reset while a WRITE is on the bus.
    @(negedge clk);
    base_addr = 7'd40; word_count = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!mem_we && guard < 20) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    chk("rst_reached_write", 32'(mem_we), 1);
    #1 rst_n = 1'b0; start = 1'b1; in_valid = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");
    run_load(30, 3, 1, 0, 0, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Write-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and packs every four bytes into one 32-bit word. Each word is written into consecutive instruction-memory entries starting at a programmable base address. Byte packing is the inverse of the memory's read-side byte swap, so a word read back presents the first streamed byte in instruction bits [31:24]. The block sits between a host/UART byte source and the instruction memory's write port.

## Interface
- MemWidth, 128, number of instruction-memory entries.
- AddrWidth, 7, address width; must satisfy 2**AddrWidth >= MemWidth.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse that launches a load; sampled only in IDLE.
- base_addr  in  AddrWidth  first entry to write; sampled with start.
- word_count  in  AddrWidth+1  number of words to load, 0..MemWidth; sampled with start.
- abort  in  1  returns the FSM to IDLE from any state; a partial word is discarded.
- in_valid  in  1  the byte source has data.
- in_byte  in  8  stream byte.
- in_ready  out  1  the loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  AddrWidth  write address.
- mem_wdata  out  32  write data.
- busy  out  1  high in ASSEMBLE and WRITE.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, ASSEMBLE, WRITE, FINISH.
- **IDLE**
  - On start with word_count == 0: go to FINISH; no writes occur.
  - On start with base_addr + word_count > MemWidth: pulse error next cycle and stay in IDLE; no writes occur.
  - Otherwise: latch base_addr into the address counter and word_count into the remaining counter, clear the byte index, then go to ASSEMBLE.
- **ASSEMBLE**
  - in_ready = 1.
  - A byte is accepted when in_valid & in_ready.
  - Byte index k (0..3) goes to shift-register bits [8k+7:8k]: first byte to [7:0], fourth byte to [31:24].
  - After the fourth accepted byte, go to WRITE.
- **WRITE**
  - Lasts exactly one cycle.
  - mem_we = 1, mem_addr = address counter, mem_wdata = packed word; in_ready = 0.
  - Next edge: increment address, decrement remaining, clear byte index.
  - If remaining was 1, go to FINISH; otherwise go to ASSEMBLE.
- **FINISH**
  - done = 1 for one cycle, then go to IDLE.
- **abort**
  - Has priority over all transitions.
  - Next state is IDLE, with no done and no error.
  - A WRITE in progress in the abort cycle still commits, because mem_we is combinational from state.
- start outside IDLE is ignored.
- in_valid outside ASSEMBLE is ignored; no byte is consumed.
- Address arithmetic is done at AddrWidth+1 bits for the overflow check. The counter never wraps, because overflow is rejected up front.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, error 0, all counters 0.
- start → in_ready high: 1 cycle.
- Word throughput with in_valid held high: 4 accept cycles + 1 WRITE cycle = 5 cycles per word.
- A load of N words finishes with done at cycle 5N+2 after start (start cycle = 0).
- mem_addr and mem_wdata are stable throughout the WRITE cycle; mem_we is never high outside WRITE.
- error and done are registered pulses, exactly one cycle wide, and are mutually exclusive.
- Reset asserted mid-load: all state clears immediately; mem_we drops asynchronously.

## Structure
- Shared package holds:
  - state enum (IDLE, ASSEMBLE, WRITE, FINISH);
  - MEM_WIDTH and ADDR_WIDTH constants, shared with the instruction memory so both agree on depth.
- Natural sub-module: inst_byte_packer, the 4-byte shift register plus index counter with accept/clear controls. The FSM and counters stay in the top module.

## Test plan
- **Basic load.** base 0, count 2, stream 8C 01 00 04 20 02 00 05 → two writes:
  - addr 0 data 0x04_00_01_8C;
  - addr 1 data 0x05_00_02_20;
  - done pulses at cycle 12;
  - reading back through the instruction memory yields 0x8C010004 and 0x20020005.
- **Back-pressure.** in_valid toggled 1-0-1-0… with count 1, base 5 → one write at addr 5 with the correct word. Bytes are never accepted while in_valid = 0, and no byte is duplicated.
- **Overflow reject.** base 126, count 3 → error pulse one cycle after start; mem_we stays 0; busy stays 0. The same block with count 2 succeeds, writing addresses 126 and 127.
- **Zero and edge counts.**
  - count 0 → done at cycle 2, no writes.
  - base 0, count 128 with continuous stream → 128 writes at addresses 0..127, done at cycle 642.
- **Abort mid-word.** count 2, abort after 2 bytes of word 1 → no further writes, no done, state IDLE. A following start loads correctly from a clean byte index.
- **Async reset mid-load.** rst_n low for 1 cycle during WRITE → mem_we drops without waiting for a clock edge and all outputs return to reset values. start is ignored while rst_n is low.
